// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: records first hit of each cover point and streams
// the global index of every newly covered point, lowest index first.
//
// state   | meaning
// IDLE    | no event presented; waiting for a pending point
// PRESENT | out_index holds an event awaiting out_ready
module toggle_cover_collector #(
  parameter int WIDTH       = 65,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8940
) (
  input  logic                         gbl_clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_index,
  output logic [$clog2(WIDTH+1)-1:0]   covered_count,
  output logic                         all_covered
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_params
    $error("toggle_cover_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hit_q;
  logic [WIDTH-1:0]  pend_q;
  logic [WIDTH-1:0]  new_hits;
  logic [WIDTH-1:0]  lowest;
  logic [WIDTH-1:0]  taken;
  logic [IW-1:0]     sel_idx;
  logic [63:0]       out_index_q, out_index_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     add_cnt;
  logic [CW:0]       sum_w;
  logic              all_cov_q;

  always_comb begin
    new_hits = valid & ~hit_q;
    // isolate the lowest pending bit
    lowest   = pend_q & (~pend_q + WIDTH'(1));

    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = IW'(i);
    end

    add_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_cnt = add_cnt + CW'(new_hits[i]);
    end

    sum_w = {1'b0, count_q} + {1'b0, add_cnt};
    if (sum_w > (CW + 1)'(WIDTH)) begin
      count_d = CW'(WIDTH);
    end else begin
      count_d = sum_w[CW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_index_d = out_index_q;
    taken       = '0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          taken       = lowest;
          out_index_d = 64'(COVER_INDEX) + 64'(sel_idx);
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (|pend_q) begin
            taken       = lowest;
            out_index_d = 64'(COVER_INDEX) + 64'(sel_idx);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // reset outranks clear; both discard the valid sampled in that cycle
  always_ff @(posedge gbl_clk) begin
    if (!reset || clear) begin
      state_q     <= IDLE;
      hit_q       <= '0;
      pend_q      <= '0;
      out_index_q <= '0;
      count_q     <= '0;
      all_cov_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_q | valid;
      pend_q      <= (pend_q & ~taken) | new_hits;
      out_index_q <= out_index_d;
      count_q     <= count_d;
      all_cov_q   <= &hit_q;
    end
  end

  assign out_valid     = (state_q == PRESENT);
  assign out_index     = out_index_q;
  assign covered_count = count_q;
  assign all_covered   = all_cov_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Scoreboard bench for toggle_cover_collector: directed scenarios plus random
// hits/stalls/clears/resets against a set-based reference model.
module tb_toggle_cover_collector;

  localparam int WIDTH = 65;
  localparam int CI    = 100;
  localparam int CW    = $clog2(WIDTH + 1);

  logic              gbl_clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  valid = '0;
  logic              out_valid;
  logic [63:0]       out_index;
  logic [CW-1:0]     covered_count;
  logic              all_covered;

  always #5 gbl_clk = ~gbl_clk;

  toggle_cover_collector #(
    .WIDTH(WIDTH), .COVER_INDEX(CI), .COVER_TOTAL(8940)
  ) dut (
    .gbl_clk(gbl_clk), .reset(reset), .clear(clear), .valid(valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_count(covered_count), .all_covered(all_covered)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int events_seen = 0;
  bit mon_en = 1'b0;

  // reference model: sets of seen/pending points and the presented event
  bit seen[WIDTH];
  bit pend_m[WIDTH];
  bit m_present = 1'b0;
  bit m_allcov = 1'b0;
  longint unsigned m_cur = 0;
  int m_count = 0;
  longint unsigned exp_q[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_pend();
    for (int i = 0; i < WIDTH; i++) if (pend_m[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [WIDTH-1:0] v, input bit rdy, input bit clr, input bit rst_n);
    bit all_before = 1'b1;
    int lo;
    for (int i = 0; i < WIDTH; i++) if (!seen[i]) all_before = 1'b0;
    if (!rst_n || clr) begin
      for (int i = 0; i < WIDTH; i++) begin
        seen[i] = 1'b0;
        pend_m[i] = 1'b0;
      end
      m_present = 1'b0;
      m_cur = 0;
      m_count = 0;
      m_allcov = 1'b0;
      return;
    end
    m_allcov = all_before;
    if (!m_present || rdy) begin
      lo = lowest_pend();
      if (lo >= 0) begin
        m_cur = CI + lo;
        pend_m[lo] = 1'b0;
        m_present = 1'b1;
      end else begin
        m_present = 1'b0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i] && !seen[i]) begin
        seen[i] = 1'b1;
        pend_m[i] = 1'b1;
        m_count++;
      end
    end
  endtask

  task automatic cycle(input logic [WIDTH-1:0] v, input bit rdy, input bit clr, input bit rst_n);
    valid = v;
    out_ready = rdy;
    clear = clr;
    reset = rst_n;
    if (rst_n && !clr && m_present && rdy) exp_q.push_back(m_cur);
    @(posedge gbl_clk);
    #1;
    model_step(v, rdy, clr, rst_n);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle('0, rdy, 1'b0, 1'b1);
  endtask

  function automatic logic [WIDTH-1:0] onebit(input int b);
    logic [WIDTH-1:0] m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  always @(negedge gbl_clk) begin
    if (mon_en) begin
      check("out_valid", out_valid, m_present);
      check("covered_count", covered_count, m_count);
      check("all_covered", all_covered, m_allcov);
      if (out_valid && m_present) check("out_index_hold", out_index, m_cur);
      if (out_valid && out_ready && reset && !clear) begin
        events_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got index %0d expected none at %0t", out_index, $time);
        end else begin
          check("event_index", out_index, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ev0;
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    check("reset_out_index", out_index, 0);
    check("reset_out_valid", out_valid, 0);

    // single hit, latency and single event
    ev0 = events_seen;
    cycle(onebit(3), 1'b1, 1'b0, 1'b1);
    check("lat_n1", out_valid, 0);
    cycle('0, 1'b1, 1'b0, 1'b1);
    check("lat_n2", out_valid, 1);
    check("lat_idx", out_index, 103);
    idle(5, 1'b1);
    check("single_events", events_seen - ev0, 1);

    // three bits in one cycle stream back to back
    ev0 = events_seen;
    cycle(onebit(0) | onebit(64) | onebit(7), 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);
    check("triple_events", events_seen - ev0, 3);
    check("triple_count", covered_count, 4);

    // stalled event 105 while bit 2 arrives
    cycle(onebit(5), 1'b0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle((i == 4) ? onebit(2) : '0, 1'b0, 1'b0, 1'b1);
    check("stall_idx", out_index, 105);
    idle(5, 1'b1);

    // repeated hits give one event
    ev0 = events_seen;
    for (int i = 0; i < 20; i++) cycle(onebit(9), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("repeat_events", events_seen - ev0, 1);

    // all ones, then clear and rehit
    cycle('0, 1'b1, 1'b1, 1'b1);
    ev0 = events_seen;
    cycle('1, 1'b1, 1'b0, 1'b1);
    idle(70, 1'b1);
    check("all_events", events_seen - ev0, 65);
    check("all_count", covered_count, 65);
    check("all_flag", all_covered, 1);
    cycle('0, 1'b1, 1'b1, 1'b1);
    check("clear_count", covered_count, 0);
    check("clear_flag", all_covered, 0);
    ev0 = events_seen;
    cycle(onebit(9), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("rehit_events", events_seen - ev0, 1);

    // reset during a stalled event
    cycle(onebit(1) | onebit(2), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    check("pre_reset_valid", out_valid, 1);
    cycle('0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", out_valid, 0);
    check("rst_count", covered_count, 0);
    ev0 = events_seen;
    idle(5, 1'b1);
    check("rst_no_stale", events_seen - ev0, 0);

    // random hits, stalls, clears, resets
    for (int c = 0; c < 2500; c++) begin
      logic [WIDTH-1:0] v;
      bit clr, rn, rdy;
      for (int b = 0; b < WIDTH; b++) v[b] = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 99) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      cycle(v, rdy, clr, rn);
    end
    idle(80, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    check("drained_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_cover_collector.md
TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 65, number of toggle cover points in the valid vector.
REQ-002 SHALL have parameter COVER_INDEX, default 0, global index of valid bit 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 8940, global cover-point count; SHALL require COVER_INDEX+WIDTH <= COVER_TOTAL.
REQ-004 SHALL have port gbl_clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous clear of all coverage state.
REQ-007 SHALL have port valid  input  WIDTH  per-cycle toggle hit bits.
REQ-008 SHALL have port out_valid  output  1  cover index event available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the event.
REQ-010 SHALL have port out_index  output  64  global cover index, COVER_INDEX + bit position.
REQ-011 SHALL have port covered_count  output  clog2(WIDTH+1)  number of distinct points hit since reset/clear.
REQ-012 SHALL have port all_covered  output  1  every point hit.

Function
REQ-013 SHALL keep sticky register hit[WIDTH-1:0]; per cycle hit <= hit | valid.
REQ-014 SHALL compute new = valid & ~hit; each set bit SHALL be reported exactly once after reset/clear; repeat hits SHALL NOT produce events.
REQ-015 SHALL keep register pend[WIDTH-1:0]; pend <= (pend & ~taken) | new; pend SHALL always be a subset of hit.
REQ-016 SHALL implement FSM IDLE / PRESENT; out_valid SHALL equal (state == PRESENT).
REQ-017 IDLE: if pend != 0, SHALL load out_index with COVER_INDEX + lowest set pend bit, clear that bit (taken), go PRESENT; else stay IDLE.
REQ-018 PRESENT: SHALL hold out_index stable while out_ready = 0.
REQ-019 PRESENT with out_ready = 1: if remaining pend != 0, SHALL load the next lowest bit in the same cycle and stay PRESENT (one event per cycle, no bubble); else go IDLE.
REQ-020 Latency: valid bit sampled in cycle N, with FSM IDLE and no lower pending bit, SHALL produce out_valid = 1 in cycle N+2.
REQ-021 New hits arriving while PRESENT stalls SHALL accumulate in pend without loss; ordering SHALL be lowest index first among pending bits at each selection.
REQ-022 covered_count SHALL increase by popcount(new) each cycle; max value WIDTH, no wrap.
REQ-023 all_covered SHALL be registered, 1 in the cycle after hit becomes all ones.
REQ-024 out_index SHALL be zero-extended 64-bit arithmetic; no truncation for any legal parameters.
REQ-025 clear = 1 SHALL, next cycle, zero hit, pend, covered_count, all_covered, out_index, force IDLE; valid sampled in the clear cycle SHALL be discarded (clear wins); an event presented during clear SHALL be dropped regardless of out_ready.
REQ-026 valid SHALL be ignored during reset.

Reset
REQ-027 reset = 0 at a rising edge SHALL set hit = 0, pend = 0, state = IDLE, out_valid = 0, out_index = 0, covered_count = 0, all_covered = 0.
REQ-028 reset asserted mid-transfer SHALL abandon the presented event with no completion; reset SHALL take priority over clear.
REQ-029 After reset deassertion, first event SHALL appear no earlier than 2 cycles after first valid hit.

Verification (WIDTH=65, COVER_INDEX=100)
REQ-030 valid = bit 3 one cycle, out_ready = 1 -> out_valid cycle N+2, out_index = 103, one event only, covered_count = 1.
REQ-031 valid = bits 0, 64 and 7 in one cycle, out_ready = 1 -> three consecutive events 100, 107, 164, no bubble, covered_count = 3.
REQ-032 out_ready = 0 for 10 cycles with event 105 presented, bit 2 hit meanwhile -> out_index stays 105; after accept next event = 102.
REQ-033 valid bit 9 repeated 20 cycles -> exactly one event 109; covered_count stays 1.
REQ-034 valid = all ones one cycle -> 65 events 100..164 in order, all_covered = 1, covered_count = 65; then clear -> all zero, out_valid = 0, bit 9 rehit -> event 109 again.
REQ-035 reset = 0 while out_valid = 1 with out_ready = 0 -> next cycle out_valid = 0, covered_count = 0, no stale event after release.
